alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised successor to the datapath ALU. It registers every result and handles single-cycle and iterative multi-cycle operations behind a valid/ready handshake. It adds signed/unsigned compare, XOR, shifts, unsigned multiply and divide with HI/LO registers, and a sticky-free divide-by-zero flag. It sits in the EX stage; the hazard unit stalls the pipeline while in_ready is low.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept; 0 while a multi-cycle op is in flight
op  in  4  operation code (see Behaviour)
a  in  WIDTH  operand 1
b  in  WIDTH  operand 2; shifts use b[SHW-1:0] as the amount, a as the data
out_valid  out  1  one-cycle pulse, result/zero valid
result  out  WIDTH  registered result
zero  out  1  registered zero/branch flag
hi  out  WIDTH  MULTU upper product / DIVU remainder
lo  out  WIDTH  MULTU lower product / DIVU quotient
busy  out  1  multi-cycle op in progress (= ~in_ready)
div_by_zero  out  1  qualifies out_valid of a DIVU with b==0

Behaviour:
- Reset is synchronous and active-low. With rst_n=0 at a rising edge:
  - result=0, zero=0, hi=0, lo=0, out_valid=0, div_by_zero=0.
  - State goes to IDLE, so in_ready=1 and busy=0.
  - Reset mid-operation aborts the operation; no out_valid is produced for it.
- Accept: in_valid && in_ready at a clock edge. Operands are captured, so a and b may change afterwards.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 NOR, 0100 OR.
  - 0101 SLT: signed a<b gives result 1, else 0.
  - 0110 EQ: result 0, zero = (a==b).
  - 0111 NE: result 0, zero = (a!=b).
  - 1000 SLTU: unsigned a<b.
  - 1001 XOR, 1010 SLL, 1011 SRL, 1100 SRA.
  - 1101 MULTU, 1110 DIVU.
  - 1111 reserved: result 0, zero 1.
- Wrap-around: ADD/SUB wrap modulo 2^WIDTH; there is no overflow output.
- zero for every op except EQ/NE/1111 is (result==0).
- Single-cycle ops: out_valid is asserted the cycle after accept (latency 1) and lasts one cycle. in_ready stays 1, so back-to-back accepts give a pulse every cycle.
- State machine: IDLE -> MUL or DIV on accept of MULTU/DIVU -> DONE -> IDLE.
  - MUL: shift-add, one bit per cycle, WIDTH cycles.
  - DIV: restoring, one quotient bit per cycle, WIDTH cycles.
  - DONE: writes hi/lo, result=lo, zero=(lo==0), and asserts out_valid. in_ready=1 in DONE, so a new op may be accepted in the DONE cycle.
  - Accept-to-out_valid latency is WIDTH+1 cycles. in_ready=0 from the cycle after accept through the last MUL/DIV cycle.
- MULTU: {hi,lo} = a*b unsigned, full 2*WIDTH product.
- DIVU: lo = a/b, hi = a%b, div_by_zero=0.
- DIVU with b==0:
  - Same latency as a normal DIVU.
  - lo = all ones, hi = a, div_by_zero=1 for the out_valid cycle only.
- hi/lo are updated only in DONE. Single-cycle ops never modify them.
- result/zero hold their value between out_valid pulses.
- in_valid while in_ready=0 is ignored. The requester must hold the request; the unit does not queue it.

Test Plan:
1. Reset: drive rst_n=0 during a MULTU in flight -> next cycle busy=0, in_ready=1, hi=lo=result=0, and no out_valid ever appears for the aborted op.
2. Single-cycle stream, WIDTH=32: ADD 0xFFFFFFFF+1 then SLT 0xFFFFFFFF,1 then SLTU same operands, on consecutive cycles -> out_valid on 3 consecutive cycles with results 0 (zero=1), 1, 0 (zero=1).
3. EQ/NE: EQ 5,5 -> result 0, zero 1; NE 5,5 -> zero 0. Shifts: SRA 0x80000000 by b=0x24 (amount 4) -> 0xF8000000; SLL 1 by 31 -> 0x80000000.
4. MULTU 0xFFFFFFFF*0xFFFFFFFF:
   - out_valid exactly 33 cycles after accept, with hi=0xFFFFFFFE, lo=0x00000001, result=1, zero=0.
   - in_ready low for 32 cycles.
   - An in_valid held during the busy window is accepted in the DONE cycle.
5. DIVU 100/7 -> lo=14, hi=2, div_by_zero=0. DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1 for one cycle, same 33-cycle latency.
6. Parameter sweep WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 cycles. Random single-cycle ops checked against a reference model for WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/alu_mc.sv
// Registered EX-stage ALU: single-cycle ops plus iterative shift-add MULTU
// and restoring DIVU behind a valid/ready handshake, results in HI/LO.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_NOR   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_EQ    = 4'h6;
  localparam logic [3:0] OP_NE    = 4'h7;
  localparam logic [3:0] OP_SLTU  = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;
  localparam logic [3:0] OP_SLL   = 4'hA;
  localparam logic [3:0] OP_SRL   = 4'hB;
  localparam logic [3:0] OP_SRA   = 4'hC;
  localparam logic [3:0] OP_MULTU = 4'hD;
  localparam logic [3:0] OP_DIVU  = 4'hE;
  localparam logic [3:0] OP_RSVD  = 4'hF;

  logic [1:0]         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               outValid_q, outValid_d;
  logic               divZero_q, divZero_d;

  logic               accept;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   aluRes;
  logic               aluZero;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] iterAcc;

  assign in_ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy        = ~in_ready;
  assign accept      = in_valid && in_ready;
  assign shamt       = b[SHW-1:0];
  assign out_valid   = outValid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = divZero_q;

  always_comb begin
    aluRes = '0;
    case (op)
      OP_ADD:  aluRes = a + b;
      OP_SUB:  aluRes = a - b;
      OP_AND:  aluRes = a & b;
      OP_NOR:  aluRes = ~(a | b);
      OP_OR:   aluRes = a | b;
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  aluRes = a ^ b;
      OP_SLL:  aluRes = a << shamt;
      OP_SRL:  aluRes = a >> shamt;
      OP_SRA:  aluRes = WIDTH'($signed(a) >>> shamt);
      default: aluRes = '0;
    endcase
    case (op)
      OP_EQ:   aluZero = (a == b);
      OP_NE:   aluZero = (a != b);
      OP_RSVD: aluZero = 1'b1;
      default: aluZero = (aluRes == '0);
    endcase
  end

  // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, opnd_q};
    if (state_q == S_DIV) begin
      if (!divDiff[WIDTH]) iterAcc = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                 iterAcc = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      iterAcc = {mulSum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    outValid_d = 1'b0;
    divZero_d  = 1'b0;
    case (state_q)
      S_MUL, S_DIV: begin
        acc_d = iterAcc;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d    = S_DONE;
          hi_d       = iterAcc[2*WIDTH-1:WIDTH];
          lo_d       = iterAcc[WIDTH-1:0];
          result_d   = iterAcc[WIDTH-1:0];
          zero_d     = (iterAcc[WIDTH-1:0] == '0);
          outValid_d = 1'b1;
          divZero_d  = (state_q == S_DIV) && (opnd_q == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (op == OP_MULTU) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, b};
            opnd_d  = a;
          end else if (op == OP_DIVU) begin
            state_d = S_DIV;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, a};
            opnd_d  = b;
          end else begin
            result_d   = aluRes;
            zero_d     = aluZero;
            outValid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      outValid_q <= 1'b0;
      divZero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      outValid_q <= outValid_d;
      divZero_q  <= divZero_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8: expected results are
// queued when an op is driven and compared when out_valid pulses.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv32, rdy32, ov32, z32, busy32, dbz32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, res32, hi32, lo32;
  logic        iv8, rdy8, ov8, z8, busy8, dbz8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8, hi8, lo8;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .result(res32), .zero(z32),
    .hi(hi32), .lo(lo32), .busy(busy32), .div_by_zero(dbz32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .result(res8), .zero(z8),
    .hi(hi8), .lo(lo8), .busy(busy8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          waited;
  logic [31:0] hiM32, loM32, hiM8, loM8;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU working on 32-bit containers masked down to w bits
  function automatic logic [32:0] refAlu(input int w, input logic [3:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, r;
    logic        z;
    longint      sa, sb;
    int          amt;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a &= mask;
    b &= mask;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    amt = int'(b) & (w - 1);
    case (op)
      4'h0: r = (a + b) & mask;
      4'h1: r = (a - b) & mask;
      4'h2: r = a & b;
      4'h3: r = ~(a | b) & mask;
      4'h4: r = a | b;
      4'h5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: r = (a < b) ? 32'd1 : 32'd0;
      4'h9: r = a ^ b;
      4'hA: r = (a << amt) & mask;
      4'hB: r = a >> amt;
      4'hC: r = 32'(sa >>> amt) & mask;
      default: r = 32'd0;
    endcase
    case (op)
      4'h6: z = (a == b);
      4'h7: z = (a != b);
      4'hF: z = 1'b1;
      default: z = (r == 32'd0);
    endcase
    return {z, r};
  endfunction

  // Drive one request, hold it until in_ready, then queue the expected outcome
  task automatic applyStimulus(input int w, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit useExp,
                               input logic [31:0] expRes, input logic expZero,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic expDbz, output int nWait);
    exp_t        e;
    logic [32:0] m;
    logic [31:0] mask, nHi, nLo;
    logic [63:0] p;
    logic        rdy;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    nWait = 0;
    @(negedge clk);
    if (w == 32) begin
      iv32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end else begin
      iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
    rdy = (w == 32) ? rdy32 : rdy8;
    while (!rdy && nWait < 200) begin
      @(negedge clk);
      nWait++;
      rdy = (w == 32) ? rdy32 : rdy8;
    end
    if (!rdy) begin
      checkOutput("acceptReady", rdy, 1'b1);
      if (w == 32) iv32 = 1'b0; else iv8 = 1'b0;
      return;
    end
    a &= mask;
    b &= mask;
    e.cyc = cycle;
    e.dbz = 1'b0;
    if (op == 4'hD || op == 4'hE) begin
      e.lat = w + 1;
      if (useExp) begin
        nHi = expHi; nLo = expLo; e.dbz = expDbz;
      end else if (op == 4'hD) begin
        p   = 64'(a) * 64'(b);
        nHi = 32'(p >> w) & mask;
        nLo = 32'(p) & mask;
      end else if (b == 32'd0) begin
        nHi = a; nLo = mask; e.dbz = 1'b1;
      end else begin
        nHi = a % b; nLo = a / b;
      end
      e.res  = nLo;
      e.zero = (nLo == 32'd0);
      if (w == 32) begin hiM32 = nHi; loM32 = nLo; end
      else begin hiM8 = nHi; loM8 = nLo; end
    end else begin
      e.lat  = 1;
      m      = refAlu(w, op, a, b);
      e.res  = useExp ? expRes : m[31:0];
      e.zero = useExp ? expZero : m[32];
    end
    e.hi = (w == 32) ? hiM32 : hiM8;
    e.lo = (w == 32) ? loM32 : loM8;
    if (w == 32) q32.push_back(e); else q8.push_back(e);
  endtask

  task automatic applyOp(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    applyStimulus(w, op, a, b, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, n);
  endtask

  task automatic dropValid(input int w);
    @(negedge clk);
    if (w == 32) iv32 = 1'b0; else iv8 = 1'b0;
  endtask

  task automatic drain(input int w);
    int n = 0;
    while (((w == 32) ? q32.size() : q8.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainQueue", (w == 32) ? q32.size() : q8.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov32 === 1'b1) begin
      if (q32.size() == 0) checkOutput("unexpectedValid32", ov32, 1'b0);
      else begin
        e = q32.pop_front();
        checkOutput("result32", res32, e.res);
        checkOutput("zero32", z32, e.zero);
        checkOutput("hi32", hi32, e.hi);
        checkOutput("lo32", lo32, e.lo);
        checkOutput("dbz32", dbz32, e.dbz);
        checkOutput("latency32", cycle - e.cyc, e.lat);
      end
    end else if (rst_n) begin
      checkOutput("dbzIdle32", dbz32, 1'b0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov8 === 1'b1) begin
      if (q8.size() == 0) checkOutput("unexpectedValid8", ov8, 1'b0);
      else begin
        e = q8.pop_front();
        checkOutput("result8", res8, e.res[7:0]);
        checkOutput("zero8", z8, e.zero);
        checkOutput("hi8", hi8, e.hi[7:0]);
        checkOutput("lo8", lo8, e.lo[7:0]);
        checkOutput("dbz8", dbz8, e.dbz);
        checkOutput("latency8", cycle - e.cyc, e.lat);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rop;
    rst_n = 1'b0;
    iv32 = 1'b0; op32 = 4'h0; a32 = '0; b32 = '0;
    iv8  = 1'b0; op8  = 4'h0; a8  = '0; b8  = '0;
    hiM32 = '0; loM32 = '0; hiM8 = '0; loM8 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstResult", res32, 32'd0);
    checkOutput("rstZero", z32, 1'b0);
    checkOutput("rstHi", hi32, 32'd0);
    checkOutput("rstLo", lo32, 32'd0);
    checkOutput("rstValid", ov32, 1'b0);
    checkOutput("rstReady", rdy32, 1'b1);
    checkOutput("rstBusy", busy32, 1'b0);
    checkOutput("rstReady8", rdy8, 1'b1);
    rst_n = 1'b1;

    // Back-to-back single-cycle stream, then compares and shifts
    applyStimulus(32, 4'h0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 0, 0, 0, waited);
    applyStimulus(32, 4'h5, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1'b0, 0, 0, 0, waited);
    applyStimulus(32, 4'h8, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 0, 0, 0, waited);
    applyStimulus(32, 4'h6, 32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 0, 0, 0, waited);
    applyStimulus(32, 4'h7, 32'd5, 32'd5, 1'b1, 32'd0, 1'b0, 0, 0, 0, waited);
    applyStimulus(32, 4'hC, 32'h8000_0000, 32'h24, 1'b1, 32'hF800_0000, 1'b0, 0, 0, 0, waited);
    applyStimulus(32, 4'hA, 32'd1, 32'd31, 1'b1, 32'h8000_0000, 1'b0, 0, 0, 0, waited);
    applyStimulus(32, 4'hF, 32'd9, 32'd3, 1'b1, 32'd0, 1'b1, 0, 0, 0, waited);

    // MULTU with an ADD held through the busy window
    applyStimulus(32, 4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 32'hFFFF_FFFE, 32'h1, 1'b0, waited);
    applyStimulus(32, 4'h0, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 0, 0, 0, waited);
    checkOutput("busyWindow", waited, 32);
    applyStimulus(32, 4'hE, 32'd100, 32'd7, 1'b1, 0, 0, 32'd2, 32'd14, 1'b0, waited);
    applyStimulus(32, 4'hE, 32'd100, 32'd0, 1'b1, 0, 0, 32'd100, 32'hFFFF_FFFF, 1'b1, waited);
    applyStimulus(32, 4'h1, 32'd2, 32'd5, 1'b1, 32'hFFFF_FFFD, 1'b0, 0, 0, 0, waited);
    dropValid(32);
    drain(32);

    // Reset while a MULTU is in flight aborts it silently
    @(negedge clk);
    iv32 = 1'b1; op32 = 4'hD; a32 = 32'h1234; b32 = 32'h5678;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", busy32, 1'b0);
    checkOutput("abortReady", rdy32, 1'b1);
    checkOutput("abortHi", hi32, 32'd0);
    checkOutput("abortLo", lo32, 32'd0);
    checkOutput("abortResult", res32, 32'd0);
    checkOutput("abortValid", ov32, 1'b0);
    rst_n = 1'b1;
    hiM32 = '0; loM32 = '0; hiM8 = '0; loM8 = '0;
    repeat (40) @(negedge clk);

    // Random single-cycle ops at WIDTH=32 plus a few random multi-cycle ones
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 13));
      if (rop == 4'hD) rop = 4'hF;
      applyOp(32, rop, $urandom(), (i % 5 == 0) ? 32'(i) : $urandom());
    end
    applyOp(32, 4'hD, $urandom(), $urandom());
    applyOp(32, 4'hE, $urandom(), $urandom_range(1, 1000));
    dropValid(32);
    drain(32);

    // WIDTH=8 directed and random
    applyStimulus(8, 4'hD, 32'hFF, 32'hFF, 1'b1, 0, 0, 32'hFE, 32'h01, 1'b0, waited);
    applyOp(8, 4'hE, 32'd200, 32'd7);
    applyOp(8, 4'hE, 32'd77, 32'd0);
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 13));
      if (rop == 4'hD) rop = 4'hF;
      applyOp(8, rop, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    dropValid(8);
    drain(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
